// File: rtl/alu32_seq_pkg.sv
// alu32_seq_pkg: shared encodings for the 32-bit two-pass ALU sequencer.
// Holds op codes, 16-bit ALU F codes, FSM states, flag/status bit indices.
package alu32_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    localparam logic [4:0] F_TSA = 5'b00000;
    localparam logic [4:0] F_INC = 5'b00001;
    localparam logic [4:0] F_DEC = 5'b00010;
    localparam logic [4:0] F_ADD = 5'b00100;
    localparam logic [4:0] F_ADC = 5'b00101;
    localparam logic [4:0] F_SUB = 5'b00110;
    localparam logic [4:0] F_SBB = 5'b00111;
    localparam logic [4:0] F_AND = 5'b01000;
    localparam logic [4:0] F_OR  = 5'b01001;
    localparam logic [4:0] F_XOR = 5'b01010;
    localparam logic [4:0] F_NOT = 5'b01011;
    localparam logic [4:0] F_SHL = 5'b10000;
    localparam logic [4:0] F_SHR = 5'b10001;
    localparam logic [4:0] F_RCL = 5'b10110;
    localparam logic [4:0] F_RCR = 5'b10111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // out_flags = {C, Z, N, V, P}
    localparam int FL_C = 4;
    localparam int FL_Z = 3;
    localparam int FL_N = 2;
    localparam int FL_V = 1;
    localparam int FL_P = 0;

    // ALU Status = {CF, ZF, NF, VF, PF, 0}
    localparam int ST_C = 5;
    localparam int ST_Z = 4;
    localparam int ST_N = 3;
    localparam int ST_V = 2;
    localparam int ST_P = 1;

    // F code for the first or second pass of a 32-bit op
    function automatic logic [4:0] pass_f(input op_e op, input logic second);
        logic [4:0] f;
        f = F_TSA;
        unique case (op)
            OP_ADD:  f = second ? F_ADC : F_ADD;
            OP_SUB:  f = second ? F_SBB : F_SUB;
            OP_AND:  f = F_AND;
            OP_OR:   f = F_OR;
            OP_XOR:  f = F_XOR;
            OP_NOT:  f = F_NOT;
            OP_SHL:  f = second ? F_RCL : F_SHL;
            OP_SHR:  f = second ? F_RCR : F_SHR;
            default: f = F_TSA;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu32_seq_alu.sv
// alu: shared 16-bit combinational ALU (arith, logic, shift/rotate-through-carry).
// Ports: f (op code), a/b operands, cin carry/borrow in, y result, status {C,Z,N,V,P,0}.
module alu
    import alu32_seq_pkg::*;
(
    input  logic [4:0]  f,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] y,
    output logic [5:0]  status
);

    logic [16:0] sum;
    logic        c;
    logic        v;

    always_comb begin
        sum = '0;
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (f)
            F_TSA: y = a;
            F_INC: begin
                sum = {1'b0, a} + 17'd1;
                y   = sum[15:0];
                c   = sum[16];
                v   = ~a[15] & y[15];
            end
            F_DEC: begin
                sum = {1'b0, a} - 17'd1;
                y   = sum[15:0];
                c   = sum[16];
                v   = a[15] & ~y[15];
            end
            F_ADD, F_ADC: begin
                sum = {1'b0, a} + {1'b0, b} + {16'd0, cin & f[0]};
                y   = sum[15:0];
                c   = sum[16];
                v   = (a[15] == b[15]) && (y[15] != a[15]);
            end
            // CF is a borrow: set when the subtraction wraps below zero
            F_SUB, F_SBB: begin
                sum = {1'b0, a} - {1'b0, b} - {16'd0, cin & f[0]};
                y   = sum[15:0];
                c   = sum[16];
                v   = (a[15] != b[15]) && (y[15] != a[15]);
            end
            F_AND: y = a & b;
            F_OR:  y = a | b;
            F_XOR: y = a ^ b;
            F_NOT: y = ~a;
            F_SHL: begin
                y = {a[14:0], 1'b0};
                c = a[15];
            end
            F_SHR: begin
                y = {1'b0, a[15:1]};
                c = a[0];
            end
            F_RCL: begin
                y = {a[14:0], cin};
                c = a[15];
            end
            F_RCR: begin
                y = {cin, a[15:1]};
                c = a[0];
            end
            default: y = '0;
        endcase
    end

    assign status = {c, ~|y, y[15], v, ~^y, 1'b0};

endmodule

// File: rtl/alu32_seq.sv
// alu32_seq: runs 32-bit ops as two passes through the shared 16-bit alu.
// Ports: clk/rst_n; in_valid/in_ready/in_op/in_a/in_b request; out_valid/out_ready/out_result/out_flags response; busy.
module alu32_seq
    import alu32_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags,
    output logic        busy
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [15:0] part_q, part_d;
    logic        carry_q, carry_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;

    logic [4:0]  alu_f;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [15:0] alu_y;
    logic [5:0]  alu_status;

    logic        active;
    logic        second;
    logic        hi_sel;
    logic        is_arith;
    logic        is_logic;
    logic        is_unary;
    logic [31:0] full;
    logic        unused_status;

    alu u_alu (
        .f      (alu_f),
        .a      (alu_a),
        .b      (alu_b),
        .cin    (alu_cin),
        .y      (alu_y),
        .status (alu_status)
    );

    assign unused_status = ^{alu_status[ST_Z], alu_status[ST_N],
                             alu_status[ST_P], alu_status[0]};

    always_comb begin
        active   = (state_q == S_PASS1) || (state_q == S_PASS2);
        second   = (state_q == S_PASS2);
        // right shifts walk high half first so the dropped bit feeds RCR
        hi_sel   = (op_q == OP_SHR) ^ second;
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        is_logic = op_q inside {OP_AND, OP_OR, OP_XOR, OP_NOT};
        is_unary = op_q inside {OP_NOT, OP_SHL, OP_SHR};
        alu_f    = F_TSA;
        alu_a    = '0;
        alu_b    = '0;
        alu_cin  = 1'b0;
        if (active) begin
            alu_f   = pass_f(op_q, second);
            alu_a   = hi_sel ? a_q[31:16] : a_q[15:0];
            alu_b   = is_unary ? 16'd0
                    : (hi_sel ? b_q[31:16] : b_q[15:0]);
            alu_cin = second && !is_logic && carry_q;
        end
        full = (op_q == OP_SHR) ? {part_q, alu_y} : {alu_y, part_q};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        part_d   = part_q;
        carry_d  = carry_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_PASS1;
                    op_d    = op_e'(in_op);
                    a_d     = in_a;
                    b_d     = in_b;
                end
            end
            S_PASS1: begin
                state_d = S_PASS2;
                part_d  = alu_y;
                carry_d = alu_status[ST_C];
            end
            S_PASS2: begin
                state_d        = S_DONE;
                result_d       = full;
                flags_d[FL_C]  = !is_logic && alu_status[ST_C];
                flags_d[FL_Z]  = ~|full;
                flags_d[FL_N]  = full[31];
                flags_d[FL_V]  = is_arith && alu_status[ST_V];
                flags_d[FL_P]  = ~^full;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            part_q   <= part_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign out_result = result_q;
    assign out_flags  = flags_q;

endmodule

// File: tb/tb_alu32_seq.sv
// tb_alu32_seq: directed scoreboard bench for the two-pass 32-bit ALU sequencer.
// Expected results are queued on request and checked when the response appears.
module tb_alu32_seq;
    import alu32_seq_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  f;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic        busy;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    alu32_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er,
                        input logic [4:0] ef);
        int n;
        sb.push_back('{r: er, f: ef});
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(32'(in_ready), 32'd1, "accept");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv(input int hold, input string tag);
        exp_t e;
        int   cnt;
        cnt = 0;
        e   = '0;
        while (!out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk(32'(cnt), 32'd2, {tag, "_lat"});
        if (sb.size() > 0) e = sb.pop_front();
        chk(32'(out_valid), 32'd1, {tag, "_valid"});
        chk(out_result, e.r, {tag, "_res"});
        chk(32'(out_flags), 32'(e.f), {tag, "_flags"});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk(32'(out_valid), 32'd1, {tag, "_hold_valid"});
            chk(out_result, e.r, {tag, "_hold_res"});
            chk(32'(out_flags), 32'(e.f), {tag, "_hold_flags"});
            chk(32'(in_ready), 32'd0, {tag, "_hold_inrdy"});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk(32'(out_valid), 32'd0, {tag, "_post_valid"});
        chk(32'(in_ready), 32'd1, {tag, "_post_inrdy"});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_op       = 3'd0;
        in_a        = '0;
        in_b        = '0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        chk(32'(in_ready), 32'd1, "rst_inrdy");
        chk(32'(out_valid), 32'd0, "rst_valid");
        chk(32'(busy), 32'd0, "rst_busy");
        chk(out_result, 32'd0, "rst_res");
        chk(32'(out_flags), 32'd0, "rst_flags");
        rst_n = 1'b1;
        @(negedge clk);

        send(OP_ADD, 32'h0000FFFF, 32'h00000001, 32'h00010000, 5'b00000);
        recv(0, "add_cross");
        send(OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b10101);
        recv(0, "sub_borrow");
        send(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b00110);
        recv(0, "add_ovf");
        send(OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00010);
        recv(0, "sub_ovf");
        send(OP_SHL, 32'h80000001, 32'hDEADBEEF, 32'h00000002, 5'b10000);
        recv(0, "shl_c");
        send(OP_SHL, 32'h80000000, 32'h00000000, 32'h00000000, 5'b11001);
        recv(0, "shl_zero");
        send(OP_SHR, 32'h00010000, 32'h12345678, 32'h00008000, 5'b00000);
        recv(0, "shr_cross");
        send(OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 5'b00101);
        recv(0, "xor");
        send(OP_NOT, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00101);
        recv(0, "not");

        // backpressure with a second request held throughout
        send(OP_OR, 32'h12340000, 32'h00005678, 32'h12345678, 5'b00000);
        in_valid = 1'b1;
        in_op    = OP_AND;
        in_a     = 32'hFF00FF00;
        in_b     = 32'h0FF00FF0;
        recv(5, "bp");
        send(OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 5'b00001);
        recv(0, "bp_second");

        // reset during PASS2 discards the operation
        send(OP_ADD, 32'h00000005, 32'h00000006, 32'h0000000B, 5'b00000);
        chk(32'(busy), 32'd1, "mid_busy");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk(32'(busy), 32'd0, "mid_rst_busy");
        chk(32'(in_ready), 32'd1, "mid_rst_inrdy");
        chk(32'(out_valid), 32'd0, "mid_rst_valid");
        chk(out_result, 32'd0, "mid_rst_res");
        chk(32'(out_flags), 32'd0, "mid_rst_flags");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk(32'(out_valid), 32'd0, "mid_rst_noresp");
        send(OP_ADD, 32'h00000001, 32'h00000001, 32'h00000002, 5'b00000);
        recv(0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu32_seq.md
# alu32_seq

Two-pass sequencer that executes 32-bit operations on the team's single 16-bit `alu` datapath. It accepts a 32-bit operation on a valid/ready request channel and drives the ALU twice, low half then high half, or high then low for right shifts. The carry/borrow between passes goes through the ALU `Cin`. It returns a 32-bit result plus flags on a valid/ready response channel. It sits between instruction decode and the shared ALU and owns the ALU for the duration of each operation.

## Interface
- No parameters; widths fixed (operand 32, ALU 16).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_op` in 3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT (A only), 6 SHL (A by 1), 7 SHR (A logical by 1).
- `in_a`, `in_b` in 32 each: operands; `in_b` ignored for NOT/SHL/SHR.
- `out_valid` out 1: response valid.
- `out_ready` in 1: response consumed when `out_valid && out_ready`.
- `out_result` out 32: result.
- `out_flags` out 5: {C, Z, N, V, P}.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, PASS1, PASS2, DONE.
  - IDLE → PASS1 on accept; op and operands are registered.
  - PASS1 → PASS2 unconditionally.
  - PASS2 → DONE unconditionally.
  - DONE → IDLE on `out_ready`.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). `busy` = (state != IDLE).
- Pass mapping, giving the ALU F code for pass1/pass2:
  - ADD: 00100 low half, then 00101 high half with Cin = pass1 CF.
  - SUB: 00110 low half, then 00111 high half with Cin = pass1 borrow (CF).
  - AND/OR/XOR/NOT: 01000/01001/01010/01011 on both halves, Cin = 0.
  - SHL: 10000 on the low half; pass1 CF = A[15]. Then 10110 (RCL) on the high half with Cin = that CF.
  - SHR: 10001 on the high half; pass1 CF = A[16]. Then 10111 (RCR) on the low half with Cin = that CF.
- Carry register: captures ALU Status[5] at the end of PASS1 and feeds `Cin` during PASS2.
- Flags are computed at the end of PASS2 and held in DONE:
  - C: pass2 ALU CF, which is the 32-bit carry/borrow or the shifted-out bit. C = 0 for logic ops.
  - Z: all 32 result bits zero.
  - N: result[31].
  - V: pass2 ALU VF for ADD/SUB; 0 for all other ops.
  - P: XNOR of all 32 result bits (1 = even number of ones).
- ALU inputs are driven to zero with F = 00000 in IDLE and DONE.

## Timing
- Reset values: state IDLE; `in_ready` 1; `out_valid` 0; `busy` 0; `out_result` 0; `out_flags` 0; carry register 0.
- Latency: request accepted at edge 0 → `out_valid` high after edge 2.
- `out_result` and `out_flags` are stable for the whole of DONE, however long `out_ready` stays low.
- Back-to-back operations are not allowed: after the DONE handshake at edge n, `in_ready` is high after edge n. Peak throughput is one operation per 4 cycles.
- Requests seen while `in_ready` = 0 are ignored. They are not queued, and the requester must hold them.
- `out_ready` outside DONE has no effect.
- Reset asserted mid-operation: immediate return to IDLE. The in-flight operation is discarded with no response; outputs take their reset values.
- All outputs are registered or decoded from state; there is no combinational path from `in_*` to `out_*`.

## Structure
- `alu32_seq_pkg`:
  - op encodings (3-bit);
  - ALU F code constants (INC…RCR);
  - FSM state enum;
  - flag bit-index constants.
- One sub-module: the existing 16-bit `alu`, instantiated once. The sequencer owns the half-select muxes, the carry register, the result/flag registers and the FSM.

## Test plan
- ADD 0x0000FFFF + 0x00000001 → result 0x00010000, flags C0 Z0 N0 V0 P0. Carry crosses the half boundary; `out_valid` rises 2 cycles after accept.
- SUB 0x00000000 − 0x00000001 → result 0xFFFFFFFF, C1 Z0 N1 V0 P1. ADD 0x7FFFFFFF + 1 → result 0x80000000, C0 N1 V1 P0.
- Shifts:
  - SHL 0x80000001 → 0x00000002, C1.
  - SHL 0x80000000 → 0x00000000, C1 Z1 P1.
  - SHR 0x00010000 → 0x00008000, C0; the high-half bit moves into the low half.
- Logic: XOR 0xFFFF0000 ^ 0x0F0F0F0F → 0xF0F00F0F, C0 V0. NOT 0x00000000 → 0xFFFFFFFF, N1 P1.
- Backpressure: hold `out_ready` low 5 cycles in DONE → `out_valid` stays 1, result/flags unchanged, `in_ready` stays 0, and a held second request is not accepted until after the response handshake.
- Reset mid-op: deassert `rst_n` during PASS2 of an ADD → state IDLE immediately, `out_valid` 0, `out_result` 0. After release, a new ADD 1 + 1 returns 0x00000002.
